sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Sequencing and arbitration controller for the 4096x32 single-port SRAM macro. It shares the macro between an instruction-fetch requester (read-only) and a data requester (read/write with byte enables), and drives the macro's power pins through an idle-sleep and shutdown state machine. It sits between the core's fetch/load-store units and the SRAM instance. The top level ties the macro's BIST-mode pins (BIST, AWT, CEBM, WEBM, AM, DM, BWEBM) inactive.

## Interface
- IDLE_CYCLES, 16: consecutive idle cycles in RUN before entering SLEEP (1..255).
- WAKE_CYCLES, 2: cycles spent in WAKE before returning to RUN (1..15).
- CLK  in  1  rising-edge clock, shared with the SRAM macro.
- RSTB  in  1  asynchronous, active-low reset.
- I_VALID / I_READY  in / out  1 / 1  fetch request handshake.
- I_ADDR  in  12  fetch word address.
- I_RVALID / I_RDATA  out  1 / 32  fetch read return; no backpressure.
- D_VALID / D_READY  in / out  1 / 1  data request handshake.
- D_WE  in  1  1 = write, 0 = read.
- D_ADDR  in  12;  D_WDATA  in  32;  D_BE  in  4  byte enables, bit n enables byte n.
- D_RVALID / D_RDATA  out  1 / 32  data read return; no backpressure.
- SD_REQ  in  1  shutdown request, level-sensitive.
- SRAM_CEB, SRAM_WEB  out  1, 1  macro chip enable and write enable, active-low.
- SRAM_A  out  12;  SRAM_D  out  32;  SRAM_BWEB  out  32  macro address, data and bit-write-enable (active-low).
- SRAM_Q  in  32  macro read data.
- SRAM_SLP, SRAM_SD  out  1, 1  macro sleep and shutdown controls.
- PWR_STATE  out  2  0 = RUN, 1 = SLEEP, 2 = WAKE, 3 = SHUTDOWN.

## Operation
- States:
  - RUN: accepts requests.
  - SLEEP: SRAM_SLP=1.
  - WAKE: SLP and SD both 0; a counter runs WAKE_CYCLES.
  - SHUTDOWN: SRAM_SD=1, contents lost.
- Ready rule: I_READY and D_READY are driven only when state==RUN and SD_REQ==0. At most one of them is high in a cycle.
- Arbitration:
  - A single requester is granted immediately.
  - When both request, round-robin: the port not granted last wins.
  - The pointer resets to favour D.
- SRAM pins are combinational from the granted request:
  - SRAM_CEB=0.
  - SRAM_WEB=~D_WE for port D, 1 for port I.
  - SRAM_BWEB[8n+7:8n] = {8{~D_BE[n]}}.
  - With no grant: CEB=1, WEB=1, BWEB all 1s.
- Reads: a 2-bit in-flight pipeline tags each read with its port. SRAM_Q is registered into the tagged port's RDATA, and RVALID pulses for exactly 1 cycle. RDATA holds its value otherwise.
- Idle counter:
  - Clears on any VALID, SD_REQ, or in-flight read.
  - Otherwise increments, saturating, in RUN.
  - At IDLE_CYCLES, moves RUN->SLEEP.
- SLEEP->WAKE on any VALID. SLEEP->SHUTDOWN on SD_REQ.
- WAKE->RUN after WAKE_CYCLES. SD_REQ during WAKE goes to SHUTDOWN.
- RUN->SHUTDOWN when SD_REQ=1 and no read is in flight. Outstanding reads complete first.
- SHUTDOWN->WAKE when SD_REQ=0.
- Requesters hold VALID and request fields stable until READY.

## Timing
- Reset values of all outputs:
  - I_READY=0, D_READY=0.
  - I_RVALID=0, D_RVALID=0, I_RDATA=0, D_RDATA=0.
  - SRAM_CEB=1, SRAM_WEB=1, SRAM_BWEB=all 1s, SRAM_A=0, SRAM_D=0.
  - SRAM_SLP=0, SRAM_SD=0.
  - PWR_STATE=RUN.
- Read latency: handshake at edge E0 (the SRAM samples at the same edge). RDATA/RVALID are valid in the cycle after E0+1 edge, i.e. 2 edges.
- Throughput: one access per cycle, with back-to-back reads pipelined.
- Writes complete at the handshake edge and produce no response.
- SRAM_SLP/SRAM_SD are registered: they assert/deassert in the cycle after the state transition edge.
- SLEEP exit to first READY: 1 + WAKE_CYCLES cycles after VALID is sampled.
- Reset asserted mid-operation: in-flight reads are dropped with no RVALID. The state returns to RUN with SLP/SD low.
- VALID and SD_REQ in the same RUN cycle: READY=0, so SD_REQ wins.

## Configuration
- SRAM_ACCESS_CTRL_AUTOSLEEP_EN defined: idle counter and SLEEP state are present, as above.
- Undefined:
  - The idle counter is removed and SLEEP is unreachable.
  - SRAM_SLP is tied 0.
  - WAKE is used only on exit from SHUTDOWN.

## Test plan
- Fetch read: I_ADDR=0x123 after a data write of 0xDEADBEEF to 0x123 -> I_RDATA=0xDEADBEEF with I_RVALID for 1 cycle, 2 edges after the handshake.
- Byte write: word 0x010 = 0x11223344, then write D_WDATA=0xAABBCCDD with D_BE=4'b0101 -> readback 0x11BB33DD. SRAM_BWEB=0xFF00FF00 during the write.
- Contention: I_VALID and D_VALID both high for 4 cycles -> grants D, I, D, I, with CEB low every cycle and returns correctly tagged.
- Auto-sleep (macro defined, IDLE_CYCLES=16, WAKE_CYCLES=2):
  - 16 idle cycles -> PWR_STATE=1, SRAM_SLP=1.
  - I_VALID then raised -> WAKE for 2 cycles, then I_READY=1 on the 3rd cycle.
- Shutdown: SD_REQ raised while one read is in flight -> the read returns, then SRAM_SD=1 and PWR_STATE=3. SD_REQ dropped -> WAKE, then RUN.
- Reset mid-read: RSTB low 1 cycle after a read handshake -> no RVALID, and all outputs at their reset values.

Source files
------------

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - fetch and data requester bundle for sram_access_ctrl
interface sram_access_ctrl_if;
  logic        i_valid;
  logic        i_ready;
  logic [11:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_valid;
  logic        d_ready;
  logic        d_we;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  modport master (
    output i_valid, i_addr, d_valid, d_we, d_addr, d_wdata, d_be,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata
  );

  modport slave (
    input  i_valid, i_addr, d_valid, d_we, d_addr, d_wdata, d_be,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - 4096x32 SRAM arbiter with read return pipeline and power sequencing
// Optional idle-sleep support enabled by defining SRAM_ACCESS_CTRL_AUTOSLEEP_EN.
module sram_access_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rstb,
  sram_access_ctrl_if.slave   req,
  input  logic                sd_req,
  output logic                sram_ceb,
  output logic                sram_web,
  output logic [11:0]         sram_a,
  output logic [31:0]         sram_d,
  output logic [31:0]         sram_bweb,
  input  logic [31:0]         sram_q,
  output logic                sram_slp,
  output logic                sram_sd,
  output logic [1:0]          pwr_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SLEEP    = 2'd1,
    ST_WAKE     = 2'd2,
    ST_SHUTDOWN = 2'd3
  } pwr_state_e;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  pwr_state_e  state;
  pwr_state_e  state_nxt;

  logic        run_ok;
  logic        grant_i;
  logic        grant_d;
  logic        prio_d;

  logic        rd_pend;
  logic        rd_tag_d;
  logic        i_rvalid_q;
  logic        d_rvalid_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic [3:0]  wake_cnt;
  logic        wake_done;
  logic        idle_hit;
  logic        sd_nxt;
  logic        sd_q;

  // Gating with rstb keeps READY low while reset is held, even if a requester is already valid.
  assign run_ok = rstb && (state == ST_RUN) && !sd_req;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (run_ok) begin
      if (req.d_valid && (!req.i_valid || prio_d)) begin
        grant_d = 1'b1;
      end else if (req.i_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  assign req.d_ready = grant_d;
  assign req.i_ready = grant_i;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prio_d <= 1'b1;
    end else if (grant_d) begin
      prio_d <= 1'b0;
    end else if (grant_i) begin
      prio_d <= 1'b1;
    end
  end

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    sram_bweb = '1;
    if (grant_d) begin
      sram_ceb = 1'b0;
      sram_web = ~req.d_we;
      sram_a   = req.d_addr;
      sram_d   = req.d_wdata;
      for (int n = 0; n < 4; n++) begin
        sram_bweb[8*n +: 8] = {8{~req.d_be[n]}};
      end
    end else if (grant_i) begin
      sram_ceb = 1'b0;
      sram_a   = req.i_addr;
    end
  end

  // The macro presents Q one edge after sampling; it is captured into the tagged port on the next edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_pend    <= 1'b0;
      rd_tag_d   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      rd_pend    <= grant_i | (grant_d & ~req.d_we);
      rd_tag_d   <= grant_d;
      i_rvalid_q <= rd_pend & ~rd_tag_d;
      d_rvalid_q <= rd_pend & rd_tag_d;
      if (rd_pend && !rd_tag_d) begin
        i_rdata_q <= sram_q;
      end
      if (rd_pend && rd_tag_d) begin
        d_rdata_q <= sram_q;
      end
    end
  end

  assign req.i_rvalid = i_rvalid_q;
  assign req.d_rvalid = d_rvalid_q;
  assign req.i_rdata  = i_rdata_q;
  assign req.d_rdata  = d_rdata_q;

`ifdef SRAM_ACCESS_CTRL_AUTOSLEEP_EN
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);

  logic [7:0] idle_cnt;
  logic       idle_now;

  assign idle_now = !(req.i_valid || req.d_valid || sd_req || rd_pend);
  assign idle_hit = (state == ST_RUN) && idle_now && (idle_cnt >= IDLE_LAST);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idle_cnt <= '0;
    end else if ((state != ST_RUN) || !idle_now) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 8'hFF) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

  assign wake_done = (wake_cnt == WAKE_LAST);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wake_cnt <= '0;
    end else if ((state == ST_WAKE) && (state_nxt == ST_WAKE)) begin
      wake_cnt <= wake_cnt + 4'd1;
    end else begin
      wake_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Shutdown waits for any outstanding read so its data is captured before the macro powers down.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (sd_req && !rd_pend) begin
          state_nxt = ST_SHUTDOWN;
        end else if (idle_hit) begin
          state_nxt = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (sd_req) begin
          state_nxt = ST_SHUTDOWN;
        end else if (req.i_valid || req.d_valid) begin
          state_nxt = ST_WAKE;
        end
      end
      ST_WAKE: begin
        if (sd_req) begin
          state_nxt = ST_SHUTDOWN;
        end else if (wake_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_SHUTDOWN: begin
        if (!sd_req) begin
          state_nxt = ST_WAKE;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    sd_nxt = (state_nxt == ST_SHUTDOWN);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sd_q <= 1'b0;
    end else begin
      sd_q <= sd_nxt;
    end
  end

`ifdef SRAM_ACCESS_CTRL_AUTOSLEEP_EN
  logic slp_nxt;
  logic slp_q;

  always_comb begin
    slp_nxt = (state_nxt == ST_SLEEP);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      slp_q <= 1'b0;
    end else begin
      slp_q <= slp_nxt;
    end
  end

  assign sram_slp = slp_q;
`else
  assign sram_slp = 1'b0;
`endif

  assign sram_sd   = sd_q;
  assign pwr_state = state;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed self-checking bench for sram_access_ctrl with a behavioural macro
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rstb;
  logic        sd_req;
  logic        sram_ceb;
  logic        sram_web;
  logic [11:0] sram_a;
  logic [31:0] sram_d;
  logic [31:0] sram_bweb;
  logic [31:0] sram_q;
  logic        sram_slp;
  logic        sram_sd;
  logic [1:0]  pwr_state;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:4095];

  sram_access_ctrl_if bus ();

  sram_access_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .req       (bus),
    .sd_req    (sd_req),
    .sram_ceb  (sram_ceb),
    .sram_web  (sram_web),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_bweb (sram_bweb),
    .sram_q    (sram_q),
    .sram_slp  (sram_slp),
    .sram_sd   (sram_sd),
    .pwr_state (pwr_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) begin
        mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_i_ready"},  {31'd0, bus.i_ready},  32'd0);
    chk({p, "_d_ready"},  {31'd0, bus.d_ready},  32'd0);
    chk({p, "_i_rvalid"}, {31'd0, bus.i_rvalid}, 32'd0);
    chk({p, "_d_rvalid"}, {31'd0, bus.d_rvalid}, 32'd0);
    chk({p, "_i_rdata"},  bus.i_rdata,           32'd0);
    chk({p, "_d_rdata"},  bus.d_rdata,           32'd0);
    chk({p, "_ceb"},      {31'd0, sram_ceb},     32'd1);
    chk({p, "_web"},      {31'd0, sram_web},     32'd1);
    chk({p, "_bweb"},     sram_bweb,             32'hFFFF_FFFF);
    chk({p, "_a"},        {20'd0, sram_a},       32'd0);
    chk({p, "_d"},        sram_d,                32'd0);
    chk({p, "_slp"},      {31'd0, sram_slp},     32'd0);
    chk({p, "_sd"},       {31'd0, sram_sd},      32'd0);
    chk({p, "_pwr"},      {30'd0, pwr_state},    32'd0);
  endtask

  initial begin
    rstb        = 1'b0;
    sd_req      = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_addr  = '0;
    bus.d_valid = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    tick();
    rstb = 1'b1;

    // Full-word write 0xDEADBEEF to 0x123
    bus.d_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h123;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'hF;
    @(negedge clk);
    chk("wr_d_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("wr_i_ready", {31'd0, bus.i_ready}, 32'd0);
    chk("wr_ceb",     {31'd0, sram_ceb},    32'd0);
    chk("wr_web",     {31'd0, sram_web},    32'd0);
    chk("wr_a",       {20'd0, sram_a},      32'h123);
    chk("wr_d",       sram_d,               32'hDEAD_BEEF);
    chk("wr_bweb",    sram_bweb,            32'd0);
    tick();
    bus.d_valid = 1'b0; bus.d_we = 1'b0;

    // Fetch read of 0x123, return two edges after the handshake
    bus.i_valid = 1'b1; bus.i_addr = 12'h123;
    @(negedge clk);
    chk("fr_i_ready", {31'd0, bus.i_ready}, 32'd1);
    chk("fr_web",     {31'd0, sram_web},    32'd1);
    chk("fr_bweb",    sram_bweb,            32'hFFFF_FFFF);
    chk("fr_a",       {20'd0, sram_a},      32'h123);
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("fr_rvalid_e1", {31'd0, bus.i_rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("fr_rvalid_e2", {31'd0, bus.i_rvalid}, 32'd1);
    chk("fr_rdata",     bus.i_rdata,           32'hDEAD_BEEF);
    chk("fr_d_rvalid",  {31'd0, bus.d_rvalid}, 32'd0);
    tick();
    @(negedge clk);
    chk("fr_rvalid_e3", {31'd0, bus.i_rvalid}, 32'd0);
    chk("fr_rdata_hold", bus.i_rdata,          32'hDEAD_BEEF);
    tick();

    // Byte-enable write: 0x11223344 then 0xAABBCCDD with be=0101
    bus.d_valid = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h010;
    bus.d_wdata = 32'h1122_3344; bus.d_be = 4'hF;
    @(negedge clk);
    chk("bw1_d_ready", {31'd0, bus.d_ready}, 32'd1);
    tick();
    bus.d_wdata = 32'hAABB_CCDD; bus.d_be = 4'b0101;
    @(negedge clk);
    chk("bw2_d_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("bw2_bweb",    sram_bweb,            32'hFF00_FF00);
    chk("bw2_web",     {31'd0, sram_web},    32'd0);
    tick();
    bus.d_we = 1'b0; bus.d_be = 4'hF;
    @(negedge clk);
    chk("br_d_ready", {31'd0, bus.d_ready}, 32'd1);
    tick();
    bus.d_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("br_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("br_d_rdata",  bus.d_rdata,           32'h11BB_33DD);
    tick();

    // Fetch of 0x010 leaves I as last grant, so D wins the first contended cycle
    bus.i_valid = 1'b1; bus.i_addr = 12'h010;
    @(negedge clk);
    chk("fr2_i_ready", {31'd0, bus.i_ready}, 32'd1);
    tick();
    bus.i_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("fr2_i_rvalid", {31'd0, bus.i_rvalid}, 32'd1);
    chk("fr2_i_rdata",  bus.i_rdata,           32'h11BB_33DD);
    tick();

    // Contention: both valid, grants alternate D, I, D, I
    bus.i_valid = 1'b1; bus.i_addr = 12'h010;
    bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h123;
    @(negedge clk);
    chk("c1_d_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("c1_i_ready", {31'd0, bus.i_ready}, 32'd0);
    chk("c1_ceb",     {31'd0, sram_ceb},    32'd0);
    chk("c1_a",       {20'd0, sram_a},      32'h123);
    tick();
    bus.d_addr = 12'h010;
    @(negedge clk);
    chk("c2_i_ready", {31'd0, bus.i_ready}, 32'd1);
    chk("c2_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("c2_ceb",     {31'd0, sram_ceb},    32'd0);
    chk("c2_a",       {20'd0, sram_a},      32'h010);
    tick();
    bus.i_addr = 12'h123;
    @(negedge clk);
    chk("c3_d_ready",  {31'd0, bus.d_ready},  32'd1);
    chk("c3_i_ready",  {31'd0, bus.i_ready},  32'd0);
    chk("c3_ceb",      {31'd0, sram_ceb},     32'd0);
    chk("c3_a",        {20'd0, sram_a},       32'h010);
    chk("c3_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("c3_d_rdata",  bus.d_rdata,           32'hDEAD_BEEF);
    chk("c3_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
    tick();
    bus.d_addr = 12'h123;
    @(negedge clk);
    chk("c4_i_ready",  {31'd0, bus.i_ready},  32'd1);
    chk("c4_d_ready",  {31'd0, bus.d_ready},  32'd0);
    chk("c4_ceb",      {31'd0, sram_ceb},     32'd0);
    chk("c4_a",        {20'd0, sram_a},       32'h123);
    chk("c4_i_rvalid", {31'd0, bus.i_rvalid}, 32'd1);
    chk("c4_i_rdata",  bus.i_rdata,           32'h11BB_33DD);
    chk("c4_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("c5_d_ready",  {31'd0, bus.d_ready},  32'd1);
    chk("c5_a",        {20'd0, sram_a},       32'h123);
    chk("c5_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("c5_d_rdata",  bus.d_rdata,           32'h11BB_33DD);
    tick();
    bus.d_valid = 1'b0;
    @(negedge clk);
    chk("c6_i_rvalid", {31'd0, bus.i_rvalid}, 32'd1);
    chk("c6_i_rdata",  bus.i_rdata,           32'hDEAD_BEEF);
    chk("c6_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
    chk("c6_ceb",      {31'd0, sram_ceb},     32'd1);
    tick();
    @(negedge clk);
    chk("c7_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("c7_d_rdata",  bus.d_rdata,           32'hDEAD_BEEF);
    tick();

    // Shutdown requested with one read in flight; a new D request waits across shutdown
    bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h123;
    @(negedge clk);
    chk("s1_d_ready", {31'd0, bus.d_ready}, 32'd1);
    tick();
    bus.d_addr = 12'h010; sd_req = 1'b1;
    @(negedge clk);
    chk("s2_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("s2_pwr",     {30'd0, pwr_state},   32'd0);
    chk("s2_sd",      {31'd0, sram_sd},     32'd0);
    tick();
    @(negedge clk);
    chk("s3_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("s3_d_rdata",  bus.d_rdata,           32'hDEAD_BEEF);
    chk("s3_pwr",      {30'd0, pwr_state},    32'd0);
    chk("s3_d_ready",  {31'd0, bus.d_ready},  32'd0);
    tick();
    @(negedge clk);
    chk("s4_pwr",     {30'd0, pwr_state},   32'd3);
    chk("s4_sd",      {31'd0, sram_sd},     32'd1);
    chk("s4_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("s4_ceb",     {31'd0, sram_ceb},    32'd1);
    tick();
    sd_req = 1'b0;
    @(negedge clk);
    chk("s5_pwr", {30'd0, pwr_state}, 32'd3);
    chk("s5_sd",  {31'd0, sram_sd},   32'd1);
    tick();
    @(negedge clk);
    chk("s6_pwr",     {30'd0, pwr_state},   32'd2);
    chk("s6_sd",      {31'd0, sram_sd},     32'd0);
    chk("s6_d_ready", {31'd0, bus.d_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("s7_pwr",     {30'd0, pwr_state},   32'd2);
    chk("s7_d_ready", {31'd0, bus.d_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("s8_pwr",     {30'd0, pwr_state},   32'd0);
    chk("s8_d_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("s8_a",       {20'd0, sram_a},      32'h010);
    tick();
    bus.d_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("s10_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("s10_d_rdata",  bus.d_rdata,           32'h11BB_33DD);
    tick();

    // Reset asserted one cycle after a fetch handshake drops the read
    bus.i_valid = 1'b1; bus.i_addr = 12'h123;
    @(negedge clk);
    chk("r1_i_ready", {31'd0, bus.i_ready}, 32'd1);
    tick();
    bus.i_valid = 1'b0; rstb = 1'b0;
    @(negedge clk);
    chk_reset_outputs("r2");
    tick();
    rstb = 1'b1;
    @(negedge clk);
    chk("r3_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
    chk("r3_pwr",      {30'd0, pwr_state},    32'd0);
    tick();
    @(negedge clk);
    chk("r4_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
    chk("r4_i_rdata",  bus.i_rdata,           32'd0);

    // Idle period: 15 idle edges since reset release, then the 16th
    repeat (14) tick();
    @(negedge clk);
    chk("idle15_pwr", {30'd0, pwr_state}, 32'd0);
    chk("idle15_slp", {31'd0, sram_slp},  32'd0);
    tick();
    @(negedge clk);
`ifdef SRAM_ACCESS_CTRL_AUTOSLEEP_EN
    chk("idle16_pwr", {30'd0, pwr_state}, 32'd1);
    chk("idle16_slp", {31'd0, sram_slp},  32'd1);
    tick();
    bus.i_valid = 1'b1; bus.i_addr = 12'h123;
    @(negedge clk);
    chk("w0_pwr",     {30'd0, pwr_state},   32'd1);
    chk("w0_i_ready", {31'd0, bus.i_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("w1_pwr",     {30'd0, pwr_state},   32'd2);
    chk("w1_slp",     {31'd0, sram_slp},    32'd0);
    chk("w1_i_ready", {31'd0, bus.i_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("w2_pwr",     {30'd0, pwr_state},   32'd2);
    chk("w2_i_ready", {31'd0, bus.i_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("w3_pwr",     {30'd0, pwr_state},   32'd0);
`else
    chk("idle16_pwr", {30'd0, pwr_state}, 32'd0);
    chk("idle16_slp", {31'd0, sram_slp},  32'd0);
    repeat (4) tick();
    @(negedge clk);
    chk("idle20_pwr", {30'd0, pwr_state}, 32'd0);
    chk("idle20_slp", {31'd0, sram_slp},  32'd0);
    tick();
    bus.i_valid = 1'b1; bus.i_addr = 12'h123;
    @(negedge clk);
`endif
    chk("post_i_ready", {31'd0, bus.i_ready}, 32'd1);
    tick();
    bus.i_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("post_i_rvalid", {31'd0, bus.i_rvalid}, 32'd1);
    chk("post_i_rdata",  bus.i_rdata,           32'hDEAD_BEEF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
